disp_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the 8-digit seven-segment display, directly upstream of the 3-to-8 anode decoder.
- Generates the digit-select index `a` that the decoder turns into active-low anode enables, plus the matching active-low segment and decimal-point drive.
- Handles per-mode digit count:
  - mode=1 (pulse monitor): 3 digits.
  - mode=0 (reaction timer): 4 digits.
- Also provides inter-digit blanking (anti-ghosting), frame-coherent data snapshot, and leading-zero suppression.

---
 rtl/disp_pkg.sv | 19 +
 rtl/disp_scan_ctrl_if.sv | 27 ++
 rtl/hex_to_sseg.sv | 34 +++
 rtl/disp_scan_ctrl.sv | 123 ++++++++++++
 tb/tb_disp_scan_ctrl.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/disp_pkg.sv
// Shared definitions for the seven-segment display paths.
// Provides the blank segment pattern, the decoder's "all anodes off" index,
// per-mode digit counts and the active-low segment type.
package disp_pkg;

  typedef logic [6:0] seg_t;  // active-low {g,f,e,d,c,b,a}

  localparam seg_t        SEG_BLANK       = 7'h7F;
  localparam logic [2:0]  DIGIT_BLANK_IDX = 3'd7;

  localparam int unsigned PULSE_DIGITS = 3;
  localparam int unsigned RT_DIGITS    = 4;

  typedef enum logic {
    MODE_RT    = 1'b0,  // reaction timer, 4 digits
    MODE_PULSE = 1'b1   // pulse monitor, 3 digits
  } mode_e;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// Display scan bus between the data source / anode decoder side (master)
// and the scan controller (slave).
//   mode, rs_en, digits, dp_mask : display content and mode, into the controller
//   a, seg_l, dp_l, slot_tick    : digit index, active-low drive, slot pulse, out
interface disp_scan_ctrl_if;
  import disp_pkg::*;

  logic        mode;
  logic        rs_en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic [2:0]  a;
  seg_t        seg_l;
  logic        dp_l;
  logic        slot_tick;

  modport master (
    output mode, rs_en, digits, dp_mask,
    input  a, seg_l, dp_l, slot_tick
  );

  modport slave (
    input  mode, rs_en, digits, dp_mask,
    output a, seg_l, dp_l, slot_tick
  );

endinterface

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low seven-segment pattern.
//   hex   : 4-bit value 0..F
//   seg_l : active-low {g,f,e,d,c,b,a}
module hex_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg_l
);

  always_comb begin
    seg_l = SEG_BLANK;
    case (hex)
      4'h0: seg_l = 7'h40;
      4'h1: seg_l = 7'h79;
      4'h2: seg_l = 7'h24;
      4'h3: seg_l = 7'h30;
      4'h4: seg_l = 7'h19;
      4'h5: seg_l = 7'h12;
      4'h6: seg_l = 7'h02;
      4'h7: seg_l = 7'h78;
      4'h8: seg_l = 7'h00;
      4'h9: seg_l = 7'h10;
      4'hA: seg_l = 7'h08;
      4'hB: seg_l = 7'h03;
      4'hC: seg_l = 7'h46;
      4'hD: seg_l = 7'h21;
      4'hE: seg_l = 7'h06;
      4'hF: seg_l = 7'h0E;
      default: seg_l = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for the 8-digit seven-segment display.
// Steps a digit index every SCAN_DIV cycles (3 digits in pulse mode, 4 in
// reaction-timer mode), blanks the anodes for BLANK_CYC cycles at the start
// of every slot, samples the display data once per frame and suppresses
// leading zeros in pulse mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of disp_scan_ctrl_if (mode, rs_en, digits,
//                dp_mask in; a, seg_l, dp_l, slot_tick out)
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  disp_scan_ctrl_if.slave   bus
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLANK_LD  = BW'(BLANK_CYC);
  localparam logic [1:0]    LIM_PULSE = 2'(PULSE_DIGITS - 1);
  localparam logic [1:0]    LIM_RT    = 2'(RT_DIGITS - 1);

  logic [CW-1:0] cnt_q,     cnt_d;
  logic [1:0]    idx_q,     idx_d;
  logic [BW-1:0] blank_q,   blank_d;
  logic [15:0]   snap_q,    snap_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic [2:0]    a_q,       a_d;
  seg_t          seg_q,     seg_d;
  logic          dp_q,      dp_d;
  logic          tick_q,    tick_d;

  logic       tick;
  logic       pulse;
  logic [1:0] lim;
  logic [3:0] nib;
  logic       suppress;
  seg_t       seg_hex;

  assign pulse = (mode_e'(bus.mode) == MODE_PULSE);
  assign lim   = pulse ? LIM_PULSE : LIM_RT;

  // Next-state: prescaler, digit index, blanking counter, frame snapshot.
  always_comb begin
    tick      = (cnt_q == CNT_MAX);
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    idx_d     = idx_q;
    blank_d   = blank_q;
    snap_d    = snap_q;
    snap_dp_d = snap_dp_q;
    tick_d    = tick;
    if (tick) begin
      // ">=" rather than "==" so a 0->1 mode switch at idx 3 still wraps.
      idx_d   = (idx_q >= lim) ? '0 : idx_q + 1'b1;
      blank_d = BLANK_LD;
      if (idx_d == '0) begin
        snap_d    = bus.digits;
        snap_dp_d = bus.dp_mask;
      end
    end else if (blank_q != '0) begin
      blank_d = blank_q - 1'b1;
    end
  end

  assign nib = snap_d[{idx_d, 2'b00} +: 4];

  hex_to_sseg u_hex (
    .hex   (nib),
    .seg_l (seg_hex)
  );

  // Output decode works on next-state values so the anode index and the
  // segment pattern register on the same edge as idx.
  always_comb begin
    suppress = pulse && (((idx_d == 2'd2) && (snap_d[11:8] == '0)) ||
                         ((idx_d == 2'd1) && (snap_d[11:4] == '0)));
    a_d   = {1'b0, idx_d};
    seg_d = suppress ? SEG_BLANK : seg_hex;
    dp_d  = ~snap_dp_d[idx_d];
    if (blank_d != '0) begin
      a_d   = DIGIT_BLANK_IDX;
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end else if (!pulse && !bus.rs_en) begin
      seg_d = SEG_BLANK;
      dp_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      blank_q   <= BLANK_LD;
      snap_q    <= '0;
      snap_dp_q <= '0;
      a_q       <= DIGIT_BLANK_IDX;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      blank_q   <= blank_d;
      snap_q    <= snap_d;
      snap_dp_q <= snap_dp_d;
      a_q       <= a_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.a         = a_q;
  assign bus.seg_l     = seg_q;
  assign bus.dp_l      = dp_q;
  assign bus.slot_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: one instance with blanking (BLANK_CYC=1) and one
// without (BLANK_CYC=0), both SCAN_DIV=4, driven by the same inputs.
module tb_disp_scan_ctrl;
  import disp_pkg::*;

  localparam int D = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode, rs_en;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        chk_en = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  disp_scan_ctrl_if bus1 ();
  disp_scan_ctrl_if bus0 ();

  assign bus1.mode = mode;    assign bus0.mode = mode;
  assign bus1.rs_en = rs_en;  assign bus0.rs_en = rs_en;
  assign bus1.digits = digits; assign bus0.digits = digits;
  assign bus1.dp_mask = dp_mask; assign bus0.dp_mask = dp_mask;

  disp_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1));
  disp_scan_ctrl #(.SCAN_DIV(4), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0));

  // ---------------- behavioural model ----------------
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int          k, cur;
  logic [15:0] snap;
  logic [3:0]  snapdp;
  logic [2:0]  e1_a, e0_a;
  logic [6:0]  e1_seg, e0_seg;
  logic        e1_dp, e0_dp, e_tick;

  function automatic logic [6:0] shown(int d, logic [15:0] s, logic m, logic en);
    int top;
    logic [15:0] t;
    if (!m && !en) return 7'h7F;
    if (m) begin
      top = 0;   // highest non-zero digit among the three shown
      for (int i = 0; i < 3; i++) if (s[i*4 +: 4] != 4'h0) top = i;
      if (d > top && d <= 2) return 7'h7F;
    end
    t = s >> (d * 4);
    return font[t[3:0]];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k = 0; cur = 0; snap = '0; snapdp = '0; e_tick = 1'b0;
      e1_a = 3'd7; e1_seg = 7'h7F; e1_dp = 1'b1;
      e0_a = 3'd7; e0_seg = 7'h7F; e0_dp = 1'b1;
    end else begin
      k = k + 1;
      e_tick = (k % D == 0);
      if (e_tick) begin
        cur = (cur + 1 < (mode ? 3 : 4)) ? cur + 1 : 0;
        if (cur == 0) begin snap = digits; snapdp = dp_mask; end
      end
      e0_a   = 3'(cur);
      e0_seg = shown(cur, snap, mode, rs_en);
      e0_dp  = (!mode && !rs_en) ? 1'b1 : ~snapdp[cur];
      if (k % D < B) begin
        e1_a = 3'd7; e1_seg = 7'h7F; e1_dp = 1'b1;
      end else begin
        e1_a = e0_a; e1_seg = e0_seg; e1_dp = e0_dp;
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_a1",    8'(bus1.a),         8'(e1_a));
      chk("m_seg1",  8'(bus1.seg_l),     8'(e1_seg));
      chk("m_dp1",   8'(bus1.dp_l),      8'(e1_dp));
      chk("m_tick1", 8'(bus1.slot_tick), 8'(e_tick));
      chk("m_a0",    8'(bus0.a),         8'(e0_a));
      chk("m_seg0",  8'(bus0.seg_l),     8'(e0_seg));
      chk("m_dp0",   8'(bus0.dp_l),      8'(e0_dp));
      chk("m_tick0", 8'(bus0.slot_tick), 8'(e_tick));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input string nm, input logic [2:0] idx,
                           input logic [6:0] sg, input logic dpv);
    int n = 0;
    @(negedge clk);
    while (bus1.a != idx && n < 40) begin @(negedge clk); n++; end
    if (bus1.a != idx) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout, a=%0d expected %0d", nm, bus1.a, idx);
    end else begin
      chk({nm, "_seg"}, 8'(bus1.seg_l), 8'(sg));
      chk({nm, "_dp"},  8'(bus1.dp_l),  8'(dpv));
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_a1"},   8'(bus1.a),         8'h07);
    chk({nm, "_seg1"}, 8'(bus1.seg_l),     8'h7F);
    chk({nm, "_dp1"},  8'(bus1.dp_l),      8'h01);
    chk({nm, "_tk1"},  8'(bus1.slot_tick), 8'h00);
    chk({nm, "_a0"},   8'(bus0.a),         8'h07);
    chk({nm, "_seg0"}, 8'(bus0.seg_l),     8'h7F);
    chk({nm, "_dp0"},  8'(bus0.dp_l),      8'h01);
    chk({nm, "_tk0"},  8'(bus0.slot_tick), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks, threes;
    rst_n = 1'b1; mode = 1'b0; rs_en = 1'b1; digits = 16'h1234; dp_mask = 4'h0;
    #2 rst_n = 1'b0;
    step(2);
    chk_reset("rst");
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // First frame shows the reset snapshot (0), second frame shows 1234.
    step(1);
    chk("e1_a1", 8'(bus1.a), 8'h00);  chk("e1_seg1", 8'(bus1.seg_l), 8'h40);
    chk("e1_a0", 8'(bus0.a), 8'h00);  chk("e1_seg0", 8'(bus0.seg_l), 8'h40);
    step(15);
    chk("e16_a1", 8'(bus1.a), 8'h07); chk("e16_tk1", 8'(bus1.slot_tick), 8'h01);
    chk("e16_a0", 8'(bus0.a), 8'h00); chk("e16_seg0", 8'(bus0.seg_l), 8'h19);
    step(1);
    chk("e17_a1", 8'(bus1.a), 8'h00); chk("e17_seg1", 8'(bus1.seg_l), 8'h19);
    step(4);
    chk("e21_a1", 8'(bus1.a), 8'h01); chk("e21_seg1", 8'(bus1.seg_l), 8'h30);
    step(4);
    chk("e25_a1", 8'(bus1.a), 8'h02); chk("e25_seg1", 8'(bus1.seg_l), 8'h24);
    step(4);
    chk("e29_a1", 8'(bus1.a), 8'h03); chk("e29_seg1", 8'(bus1.seg_l), 8'h79);

    // Pulse mode with leading-zero suppression.
    mode = 1'b1; digits = 16'h0072;
    step(24);
    expect_at("p72_d2", 3'd2, 7'h7F, 1'b1);
    expect_at("p72_d1", 3'd1, 7'h78, 1'b1);
    expect_at("p72_d0", 3'd0, 7'h24, 1'b1);
    digits = 16'h0005;
    step(24);
    expect_at("p5_d2", 3'd2, 7'h7F, 1'b1);
    expect_at("p5_d1", 3'd1, 7'h7F, 1'b1);
    expect_at("p5_d0", 3'd0, 7'h12, 1'b1);

    // Reaction timer disabled: scan runs, segments dark.
    mode = 1'b0; rs_en = 1'b0; digits = 16'h1234;
    step(20);
    expect_at("dis_d3", 3'd3, 7'h7F, 1'b1);
    ticks = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus1.slot_tick) ticks++;
    end
    chk("dis_ticks", 8'(ticks), 8'd4);

    // Frame coherence: data change at idx 2 does not tear the frame.
    rs_en = 1'b1; digits = 16'h1111;
    step(20);
    expect_at("tear_d2", 3'd2, 7'h79, 1'b1);
    digits = 16'h2222;
    expect_at("tear_d3", 3'd3, 7'h79, 1'b1);
    expect_at("tear_n0", 3'd0, 7'h24, 1'b1);
    expect_at("tear_n1", 3'd1, 7'h24, 1'b1);

    // Mode switch at idx 3 wraps straight to 0; dp on digit 1 only.
    dp_mask = 4'b0010;
    step(20);
    expect_at("sw_d3", 3'd3, 7'h24, 1'b1);
    mode = 1'b1;
    expect_at("sw_d0", 3'd0, 7'h24, 1'b1);
    expect_at("sw_d1", 3'd1, 7'h24, 1'b0);
    expect_at("sw_d2", 3'd2, 7'h24, 1'b1);
    threes = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (bus1.a == 3'd3) threes++;
    end
    chk("sw_no3", 8'(threes), 8'd0);

    // Asynchronous reset mid-slot.
    expect_at("ar_d2", 3'd2, 7'h24, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_reset("arst");
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("ar_a1", 8'(bus1.a), 8'h00); chk("ar_seg1", 8'(bus1.seg_l), 8'h40);
    step(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
